// File: rtl/elc3_pkg.sv
// Shared LC-3 datapath types and constants.
package elc3_pkg;

  localparam int unsigned WORD_W  = 16;
  localparam int unsigned NUM_GPR = 8;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } cc_t;

  localparam cc_t CC_N     = 3'b100;
  localparam cc_t CC_Z     = 3'b010;
  localparam cc_t CC_P     = 3'b001;
  localparam cc_t CC_RESET = CC_Z;

endpackage

// File: rtl/nzp_gen.sv
// Combinational NZP classifier: negative, zero or positive (two's complement).
module nzp_gen
  import elc3_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic [WIDTH-1:0] value_i,
  output cc_t              cc_o
);

  always_comb begin
    cc_o = CC_P;
    if (value_i[WIDTH-1]) begin
      cc_o = CC_N;
    end else if (value_i == '0) begin
      cc_o = CC_Z;
    end
  end

endmodule

// File: rtl/reg_file.sv
// LC-3 general-purpose register file: one synchronous write port, two
// asynchronous read ports with optional write bypass, and the NZP register.
module reg_file
  import elc3_pkg::*;
#(
  parameter  int unsigned WIDTH  = WORD_W,
  parameter  int unsigned DEPTH  = NUM_GPR,
  parameter  int unsigned BYPASS = 1,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [WIDTH-1:0]  WrData,
  input  logic              SetCC,
  input  logic [ADDR_W-1:0] RdAddrA,
  output logic [WIDTH-1:0]  RdDataA,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic [WIDTH-1:0]  RdDataB,
  output logic [2:0]        CC
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  cc_t              cc_q, cc_d;
  cc_t              wr_cc;
  logic             wr_ok;
  logic             byp_ok;

  // Addresses beyond DEPTH only exist when DEPTH is not a power of two.
  assign wr_ok  = WrEn && (32'(WrAddr) < DEPTH);
  assign byp_ok = (BYPASS != 0) && !Reset && wr_ok;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok) begin
      mem_q[WrAddr] <= WrData;
    end
  end

  always_comb begin
    RdDataA = '0;
    if (32'(RdAddrA) < DEPTH) begin
      RdDataA = mem_q[RdAddrA];
    end
    if (byp_ok && (RdAddrA == WrAddr)) begin
      RdDataA = WrData;
    end
  end

  always_comb begin
    RdDataB = '0;
    if (32'(RdAddrB) < DEPTH) begin
      RdDataB = mem_q[RdAddrB];
    end
    if (byp_ok && (RdAddrB == WrAddr)) begin
      RdDataB = WrData;
    end
  end

  nzp_gen #(.WIDTH(WIDTH)) u_nzp_gen (
    .value_i (WrData),
    .cc_o    (wr_cc)
  );

  always_comb begin
    cc_d = cc_q;
    if (SetCC) begin
      cc_d = wr_cc;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cc_q <= CC_RESET;
    end else begin
      cc_q <= cc_d;
    end
  end

  assign CC = cc_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench: default, no-bypass and 6-deep register files.
module tb_reg_file;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  // default parameters (BYPASS=1)
  logic        wen1, set1;
  logic [2:0]  wa1, ra1, rb1;
  logic [15:0] wd1, rda1, rdb1;
  logic [2:0]  cc1;
  // BYPASS=0
  logic        wen0, set0;
  logic [2:0]  wa0, ra0, rb0;
  logic [15:0] wd0, rda0, rdb0;
  logic [2:0]  cc0;
  // WIDTH=8, DEPTH=6
  logic        wen6, set6;
  logic [2:0]  wa6, ra6, rb6;
  logic [7:0]  wd6, rda6, rdb6;
  logic [2:0]  cc6;

  int total = 0;
  int bad   = 0;

  reg_file u_dut1 (
    .Clk(Clk), .Reset(Reset), .WrEn(wen1), .WrAddr(wa1), .WrData(wd1),
    .SetCC(set1), .RdAddrA(ra1), .RdDataA(rda1), .RdAddrB(rb1),
    .RdDataB(rdb1), .CC(cc1)
  );

  reg_file #(.BYPASS(0)) u_dut0 (
    .Clk(Clk), .Reset(Reset), .WrEn(wen0), .WrAddr(wa0), .WrData(wd0),
    .SetCC(set0), .RdAddrA(ra0), .RdDataA(rda0), .RdAddrB(rb0),
    .RdDataB(rdb0), .CC(cc0)
  );

  reg_file #(.WIDTH(8), .DEPTH(6), .BYPASS(1)) u_dut6 (
    .Clk(Clk), .Reset(Reset), .WrEn(wen6), .WrAddr(wa6), .WrData(wd6),
    .SetCC(set6), .RdAddrA(ra6), .RdDataA(rda6), .RdAddrB(rb6),
    .RdDataB(rdb6), .CC(cc6)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    wen1 = 1'b1; wa1 = 3'd3; wd1 = 16'h1234;
    tick();
    wen1 = 1'b0; ra1 = 3'd3;
    #1;
    total++;
    if (rda1 !== 16'h1234) begin
      bad++; $display("FAIL preload_r3 got=%h exp=1234", rda1);
    end
    Reset = 1'b1; wen1 = 1'b1; wa1 = 3'd3; wd1 = 16'hFFFF; set1 = 1'b1;
    #1;
    total++;
    if (rda1 !== 16'h1234) begin
      bad++; $display("FAIL reset_no_bypass got=%h exp=1234", rda1);
    end
    tick();
    Reset = 1'b0; wen1 = 1'b0; set1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra1 = 3'(i); rb1 = 3'(7 - i);
      #1;
      total++;
      if (rda1 !== 16'h0000 || rdb1 !== 16'h0000) begin
        bad++; $display("FAIL reset_r%0d got=%h/%h exp=0000", i, rda1, rdb1);
      end
    end
    total++;
    if (cc1 !== 3'b010) begin
      bad++; $display("FAIL reset_cc got=%b exp=010", cc1);
    end
  endtask

  task automatic test_write_read();
    wen1 = 1'b1; wa1 = 3'd5; wd1 = 16'hBEEF;
    tick();
    wen1 = 1'b0; ra1 = 3'd5; rb1 = 3'd5;
    #1;
    total++;
    if (rda1 !== 16'hBEEF || rdb1 !== 16'hBEEF) begin
      bad++; $display("FAIL write_read_r5 got=%h/%h exp=beef", rda1, rdb1);
    end
    ra1 = 3'd4; rb1 = 3'd6;
    #1;
    total++;
    if (rda1 !== 16'h0000 || rdb1 !== 16'h0000) begin
      bad++; $display("FAIL write_neighbours got=%h/%h exp=0000", rda1, rdb1);
    end
  endtask

  task automatic test_bypass();
    wen1 = 1'b1; wa1 = 3'd2; wd1 = 16'hA5A5; ra1 = 3'd2;
    wen0 = 1'b1; wa0 = 3'd2; wd0 = 16'hA5A5; ra0 = 3'd2;
    #1;
    total++;
    if (rda1 !== 16'hA5A5) begin
      bad++; $display("FAIL bypass_on got=%h exp=a5a5", rda1);
    end
    total++;
    if (rda0 !== 16'h0000) begin
      bad++; $display("FAIL bypass_off_before got=%h exp=0000", rda0);
    end
    tick();
    wen1 = 1'b0; wen0 = 1'b0;
    #1;
    total++;
    if (rda1 !== 16'hA5A5) begin
      bad++; $display("FAIL bypass_on_after got=%h exp=a5a5", rda1);
    end
    total++;
    if (rda0 !== 16'hA5A5) begin
      bad++; $display("FAIL bypass_off_after got=%h exp=a5a5", rda0);
    end
  endtask

  task automatic test_cc();
    logic [15:0] vals [4];
    logic        sets [4];
    logic [2:0]  exps [4];
    vals = '{16'h8000, 16'h0000, 16'h7FFF, 16'h8000};
    sets = '{1'b1, 1'b1, 1'b1, 1'b0};
    exps = '{3'b100, 3'b010, 3'b001, 3'b001};
    wen1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set1 = sets[i]; wd1 = vals[i];
      tick();
      total++;
      if (cc1 !== exps[i]) begin
        bad++; $display("FAIL cc_%0d wd=%h got=%b exp=%b", i, vals[i], cc1, exps[i]);
      end
    end
    set1 = 1'b0;
  endtask

  task automatic test_depth6();
    wen6 = 1'b1; wa6 = 3'd5; wd6 = 8'h3C;
    tick();
    wa6 = 3'd7; wd6 = 8'h55; ra6 = 3'd7; rb6 = 3'd5;
    #1;
    total++;
    if (rda6 !== 8'h00 || rdb6 !== 8'h3C) begin
      bad++; $display("FAIL oob_same_cycle got=%h/%h exp=00/3c", rda6, rdb6);
    end
    tick();
    wen6 = 1'b0;
    #1;
    total++;
    if (rda6 !== 8'h00 || rdb6 !== 8'h3C) begin
      bad++; $display("FAIL oob_after got=%h/%h exp=00/3c", rda6, rdb6);
    end
    for (int i = 0; i < 5; i++) begin
      ra6 = 3'(i);
      #1;
      total++;
      if (rda6 !== 8'h00) begin
        bad++; $display("FAIL oob_r%0d got=%h exp=00", i, rda6);
      end
    end
    ra6 = 3'd6;
    #1;
    total++;
    if (rda6 !== 8'h00) begin
      bad++; $display("FAIL oob_read6 got=%h exp=00", rda6);
    end
  endtask

  task automatic test_simultaneous();
    wen1 = 1'b1; set1 = 1'b1; wa1 = 3'd1; wd1 = 16'hFFFE;
    ra1 = 3'd1; rb1 = 3'd0;
    #1;
    total++;
    if (rda1 !== 16'hFFFE || rdb1 !== 16'h0000) begin
      bad++; $display("FAIL simul_read got=%h/%h exp=fffe/0000", rda1, rdb1);
    end
    tick();
    wen1 = 1'b0; set1 = 1'b0;
    #1;
    total++;
    if (cc1 !== 3'b100) begin
      bad++; $display("FAIL simul_cc got=%b exp=100", cc1);
    end
    total++;
    if (rda1 !== 16'hFFFE) begin
      bad++; $display("FAIL simul_store got=%h exp=fffe", rda1);
    end
  endtask

  task automatic test_back_to_back();
    wen1 = 1'b1; wa1 = 3'd7; wd1 = 16'h1111; ra1 = 3'd7; rb1 = 3'd6;
    tick();
    wa1 = 3'd6; wd1 = 16'h2222;
    #1;
    total++;
    if (rda1 !== 16'h1111 || rdb1 !== 16'h2222) begin
      bad++; $display("FAIL b2b_mid got=%h/%h exp=1111/2222", rda1, rdb1);
    end
    tick();
    wen1 = 1'b0;
    #1;
    total++;
    if (rda1 !== 16'h1111 || rdb1 !== 16'h2222) begin
      bad++; $display("FAIL b2b_end got=%h/%h exp=1111/2222", rda1, rdb1);
    end
  endtask

  initial begin
    Reset = 1'b1;
    wen1 = 1'b0; set1 = 1'b0; wa1 = '0; ra1 = '0; rb1 = '0; wd1 = '0;
    wen0 = 1'b0; set0 = 1'b0; wa0 = '0; ra0 = '0; rb0 = '0; wd0 = '0;
    wen6 = 1'b0; set6 = 1'b0; wa6 = '0; ra6 = '0; rb6 = '0; wd6 = '0;
    tick();
    tick();
    Reset = 1'b0;
    test_reset();
    test_write_read();
    test_bypass();
    test_cc();
    test_depth6();
    test_simultaneous();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Parametrised general-purpose register file for the LC-3 datapath; replaces discrete per-register instances for R0–R7.
- Provides one synchronous write port and two asynchronous read ports (SR1/SR2).
- Includes optional write-to-read bypass and an integrated NZP condition-code register updated from the write data.
- Sits between the decode/control FSM and the ALU operand muxes.

Parameters:
- WIDTH, 16, data width of each register in bits.
- DEPTH, 8, number of registers; legal range 2 to 64.
- BYPASS, 1, when 1, a read of the address being written in the same cycle returns write data.
- ADDR_W, $clog2(DEPTH), address width; derived, never overridden.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- WrEn  in  1  write enable (LD.REG).
- WrAddr  in  ADDR_W  destination register (DR).
- WrData  in  WIDTH  data to write.
- SetCC  in  1  update condition codes from WrData (LD.CC).
- RdAddrA  in  ADDR_W  read port A address (SR1).
- RdDataA  out  WIDTH  read port A data.
- RdAddrB  in  ADDR_W  read port B address (SR2).
- RdDataB  out  WIDTH  read port B data.
- CC  out  3  condition codes {N,Z,P}, registered.

Behaviour:
- Reset and clock:
  - Reset is synchronous, active-high; clock is Clk.
  - On a rising edge with Reset=1: all registers become 0 and CC becomes 3'b010 (Z).
  - Reset has priority over WrEn and SetCC in the same cycle.
- Write: on a rising edge with Reset=0, WrEn=1 and WrAddr<DEPTH, mem[WrAddr] <= WrData. One-cycle write latency.
- Read:
  - Combinational, zero latency: RdDataX = mem[RdAddrX].
  - Both ports are independent; identical addresses on A and B are legal.
- Bypass:
  - Applies when BYPASS=1, Reset=0, WrEn=1, WrAddr<DEPTH and RdAddrX==WrAddr.
  - Under those conditions RdDataX = WrData in the same cycle.
  - With BYPASS=0, the read returns the old value until the next cycle.
  - During a Reset cycle, reads never bypass and return stored (pre-reset) contents.
- Out of range (only possible when DEPTH is not a power of 2):
  - A write to an address ≥ DEPTH is ignored.
  - A read from an address ≥ DEPTH returns 0.
- Condition codes:
  - On a rising edge with Reset=0 and SetCC=1, CC <= nzp(WrData), independent of WrEn.
  - nzp rule: WrData[WIDTH-1]=1 gives 100; WrData==0 gives 010; otherwise 001.
  - CC is always one-hot after reset.
  - SetCC=0 holds CC.
- Simultaneous events:
  - Write plus SetCC in the same cycle: both take effect, and CC reflects the value written.
  - Write plus two reads of the same address: both ports follow the bypass rule.
- No X propagation: every register has a defined reset value, and outputs are never X after the first reset edge.

Decomposition:
- Shared package elc3_pkg:
  - WORD_W = 16 and NUM_GPR = 8.
  - typedef cc_t (3-bit packed {n,z,p}).
  - Constants CC_N = 3'b100, CC_Z = 3'b010, CC_P = 3'b001.
  - CC_RESET = CC_Z.
- One combinational sub-module, nzp_gen (WIDTH parameter; input value; output cc_t).
  - Reused later by the memory-load path.
- Storage is an unpacked array inside reg_file; no further sub-modules.

Test Plan:
- Reset with default parameters: preload R3=16'h1234, assert Reset for one cycle with WrEn=1, WrAddr=3, WrData=16'hFFFF -> R0..R7 all read 16'h0000 and CC=3'b010 the next cycle.
- Write then read: write R5=16'hBEEF, next cycle RdAddrA=5 and RdAddrB=5 -> both ports read 16'hBEEF; R4 and R6 remain 16'h0000.
- Bypass:
  - BYPASS=1: WrEn=1, WrAddr=2, WrData=16'hA5A5 with RdAddrA=2 in the same cycle -> RdDataA=16'hA5A5 before the edge.
  - BYPASS=0, same stimulus -> RdDataA holds the old value 16'h0000 until after the edge.
- CC update:
  - SetCC with WrData=16'h8000 -> CC=100.
  - SetCC with WrData=16'h0000 -> CC=010.
  - SetCC with WrData=16'h7FFF -> CC=001.
  - SetCC=0 with WrData=16'h8000 -> CC unchanged.
- Non-power-of-2 depth (WIDTH=8, DEPTH=6): write address 7 with 8'h55 -> no register changes; reading address 7 returns 8'h00; reading address 5 returns its prior value.
- Simultaneous: WrEn=1, SetCC=1, WrAddr=1, WrData=16'hFFFE, RdAddrA=1, RdAddrB=0 -> RdDataA=16'hFFFE (bypass), RdDataB=16'h0000, CC=100 after the edge.
